// File: rtl/alu_main.sv
// alu_main: strobe-loaded operand/opcode registers feeding a registered 8-bit ALU
module alu_main (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] numLeft,
  input  logic       clkNumLeft,
  input  logic [7:0] numRight,
  input  logic       clkNumRight,
  input  logic [7:0] opChoose,
  input  logic       clkOpChoose,
  output logic [7:0] result
);
  logic [7:0] regL, regR, regOp, aluOut;
  logic       prevL, prevR, prevOp;
  logic [2:0] sh;
  logic       c;
  assign sh = regR[2:0];
  assign c  = regOp[4];
  // Strobes are level signals in the clk domain; load only on a sampled 0->1 transition
  always_ff @(posedge clk) begin
    if (rst) begin
      {regL, regR, regOp} <= '0;
      {prevL, prevR, prevOp} <= '0;
    end else begin
      prevL  <= clkNumLeft;
      prevR  <= clkNumRight;
      prevOp <= clkOpChoose;
      if (clkNumLeft && !prevL)   regL  <= numLeft;
      if (clkNumRight && !prevR)  regR  <= numRight;
      if (clkOpChoose && !prevOp) regOp <= opChoose;
    end
  end
  // Combinational ALU on the current register contents; reserved opcode bits never reach here
  always_comb begin
    aluOut = 8'h00;
    case (regOp[3:0])
      4'h0: aluOut = regL;
      4'h1: aluOut = regL + regR + {7'b0, c};
      4'h2: aluOut = regL - regR - {7'b0, c};
      4'h3: aluOut = regL & regR;
      4'h4: aluOut = regL | regR;
      4'h5: aluOut = regL ^ regR;
      4'h6: aluOut = ~regL;
      4'h7: aluOut = regL << sh;
      4'h8: aluOut = regL >> sh;
      4'h9: aluOut = (regL << sh) | (regL >> (4'd8 - {1'b0, sh}));
      4'hA: aluOut = (regL >> sh) | (regL << (4'd8 - {1'b0, sh}));
      4'hB: aluOut = regL + 8'd1;
      4'hC: aluOut = regL - 8'd1;
      4'hD: aluOut = regL * regR;
      4'hE: aluOut = {7'b0, regL < regR};
      default: aluOut = 8'h00;
    endcase
  end
  // Result register refreshes every cycle, giving one cycle of latency after a load
  always_ff @(posedge clk) begin
    if (rst) result <= 8'h00;
    else     result <= aluOut;
  end
endmodule

// File: tb/tb_alu_main.sv
// tb_alu_main: directed self-checking bench for alu_main
module tb_alu_main;
  logic       clk = 0, rst = 0;
  logic [7:0] numLeft = 0, numRight = 0, opChoose = 0;
  logic       clkNumLeft = 0, clkNumRight = 0, clkOpChoose = 0;
  logic [7:0] result;
  int checks = 0, failures = 0;

  alu_main dut (
    .clk(clk), .rst(rst),
    .numLeft(numLeft), .clkNumLeft(clkNumLeft),
    .numRight(numRight), .clkNumRight(clkNumRight),
    .opChoose(opChoose), .clkOpChoose(clkOpChoose),
    .result(result)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present data, pulse the strobes in mask {L,R,Op} for one cycle, then wait for the result
  task automatic load(input logic [7:0] l, r, op, input logic [2:0] m);
    numLeft = l;
    numRight = r;
    opChoose = op;
    {clkNumLeft, clkNumRight, clkOpChoose} = m;
    tick();
    {clkNumLeft, clkNumRight, clkOpChoose} = 3'b000;
    tick();
  endtask

  task automatic test_reset();
    rst = 1;
    tick();
    tick();
    checks++; if (result !== 8'h00) begin failures++; $display("FAIL reset got=%h exp=00", result); end
    rst = 0;
    repeat (4) tick();
    checks++; if (result !== 8'h00) begin failures++; $display("FAIL idle_after_reset got=%h exp=00", result); end
  endtask

  task automatic test_add_carry();
    numLeft = 8'd3; numRight = 8'd11; opChoose = 8'h11;
    {clkNumLeft, clkNumRight, clkOpChoose} = 3'b111;
    tick();
    {clkNumLeft, clkNumRight, clkOpChoose} = 3'b000;
    checks++; if (result !== 8'h00) begin failures++; $display("FAIL latency_load_edge got=%h exp=00", result); end
    tick();
    checks++; if (result !== 8'h0F) begin failures++; $display("FAIL add_carry got=%h exp=0f", result); end
    repeat (3) tick();
    checks++; if (result !== 8'h0F) begin failures++; $display("FAIL add_carry_held got=%h exp=0f", result); end
  endtask

  task automatic test_wrap();
    load(8'hFF, 8'h01, 8'h01, 3'b111);
    checks++; if (result !== 8'h00) begin failures++; $display("FAIL add_wrap got=%h exp=00", result); end
    load(8'h00, 8'h01, 8'h01, 3'b110);
    load(8'h00, 8'h00, 8'h12, 3'b001);
    checks++; if (result !== 8'hFE) begin failures++; $display("FAIL sub_borrow got=%h exp=fe", result); end
    load(8'h00, 8'h00, 8'h02, 3'b001);
    checks++; if (result !== 8'hFF) begin failures++; $display("FAIL sub_wrap got=%h exp=ff", result); end
  endtask

  task automatic test_held_strobe();
    load(8'h00, 8'h00, 8'h00, 3'b111);
    numLeft = 8'h10;
    clkNumLeft = 1;
    tick();
    numLeft = 8'h20;
    repeat (4) tick();
    checks++; if (result !== 8'h10) begin failures++; $display("FAIL held_single_load got=%h exp=10", result); end
    clkNumLeft = 0;
    tick();
    checks++; if (result !== 8'h10) begin failures++; $display("FAIL held_release got=%h exp=10", result); end
    clkNumLeft = 1;
    tick();
    clkNumLeft = 0;
    tick();
    checks++; if (result !== 8'h20) begin failures++; $display("FAIL second_pulse got=%h exp=20", result); end
  endtask

  task automatic test_shift_rotate();
    load(8'h81, 8'h01, 8'h09, 3'b111);
    checks++; if (result !== 8'h03) begin failures++; $display("FAIL rotl got=%h exp=03", result); end
    load(8'h00, 8'h00, 8'h0A, 3'b001);
    checks++; if (result !== 8'hC0) begin failures++; $display("FAIL rotr got=%h exp=c0", result); end
    load(8'h00, 8'h00, 8'h07, 3'b001);
    checks++; if (result !== 8'h02) begin failures++; $display("FAIL shl got=%h exp=02", result); end
    load(8'h00, 8'h00, 8'h08, 3'b001);
    checks++; if (result !== 8'h40) begin failures++; $display("FAIL shr got=%h exp=40", result); end
    load(8'h00, 8'h03, 8'h0D, 3'b011);
    checks++; if (result !== 8'h83) begin failures++; $display("FAIL mul_low got=%h exp=83", result); end
    load(8'h00, 8'h08, 8'h09, 3'b011);
    checks++; if (result !== 8'h81) begin failures++; $display("FAIL rotl_zero got=%h exp=81", result); end
    load(8'h00, 8'h00, 8'h0A, 3'b001);
    checks++; if (result !== 8'h81) begin failures++; $display("FAIL rotr_zero got=%h exp=81", result); end
    load(8'h00, 8'h00, 8'h07, 3'b001);
    checks++; if (result !== 8'h81) begin failures++; $display("FAIL shl_zero got=%h exp=81", result); end
  endtask

  task automatic test_compare();
    load(8'h05, 8'h09, 8'h0E, 3'b111);
    checks++; if (result !== 8'h01) begin failures++; $display("FAIL lt_true got=%h exp=01", result); end
    load(8'h09, 8'h05, 8'h0E, 3'b111);
    checks++; if (result !== 8'h00) begin failures++; $display("FAIL lt_false got=%h exp=00", result); end
    load(8'h05, 8'h09, 8'hE3, 3'b111);
    checks++; if (result !== 8'h01) begin failures++; $display("FAIL reserved_ignored got=%h exp=01", result); end
  endtask

  task automatic test_misc_ops();
    load(8'h0F, 8'h01, 8'h13, 3'b111);
    checks++; if (result !== 8'h01) begin failures++; $display("FAIL carry_ignored_and got=%h exp=01", result); end
    load(8'h00, 8'h00, 8'h04, 3'b001);
    checks++; if (result !== 8'h0F) begin failures++; $display("FAIL or got=%h exp=0f", result); end
    load(8'h00, 8'h00, 8'h05, 3'b001);
    checks++; if (result !== 8'h0E) begin failures++; $display("FAIL xor got=%h exp=0e", result); end
    load(8'h00, 8'h00, 8'h06, 3'b001);
    checks++; if (result !== 8'hF0) begin failures++; $display("FAIL not got=%h exp=f0", result); end
    load(8'h00, 8'h00, 8'h1B, 3'b001);
    checks++; if (result !== 8'h10) begin failures++; $display("FAIL inc got=%h exp=10", result); end
    load(8'h00, 8'h00, 8'h0C, 3'b001);
    checks++; if (result !== 8'h0E) begin failures++; $display("FAIL dec got=%h exp=0e", result); end
    load(8'h00, 8'h00, 8'h0F, 3'b001);
    checks++; if (result !== 8'h00) begin failures++; $display("FAIL zero_op got=%h exp=00", result); end
  endtask

  task automatic test_reset_mid();
    load(8'd3, 8'd11, 8'h11, 3'b111);
    numLeft = 8'h07; numRight = 8'h01; opChoose = 8'h01;
    {clkNumLeft, clkNumRight, clkOpChoose} = 3'b111;
    rst = 1;
    tick();
    checks++; if (result !== 8'h00) begin failures++; $display("FAIL rst_mid got=%h exp=00", result); end
    rst = 0;
    {clkNumLeft, clkNumRight, clkOpChoose} = 3'b000;
    tick();
    tick();
    checks++; if (result !== 8'h00) begin failures++; $display("FAIL rst_overrides_load got=%h exp=00", result); end
    {clkNumLeft, clkNumRight, clkOpChoose} = 3'b111;
    rst = 1;
    tick();
    rst = 0;
    tick();
    checks++; if (result !== 8'h00) begin failures++; $display("FAIL post_rst_load_edge got=%h exp=00", result); end
    tick();
    checks++; if (result !== 8'h08) begin failures++; $display("FAIL post_rst_load got=%h exp=08", result); end
    {clkNumLeft, clkNumRight, clkOpChoose} = 3'b000;
    numLeft = 8'hAA;
    repeat (2) tick();
    checks++; if (result !== 8'h08) begin failures++; $display("FAIL data_no_effect got=%h exp=08", result); end
  endtask

  initial begin
    test_reset();
    test_add_carry();
    test_wrap();
    test_held_strobe();
    test_shift_rotate();
    test_compare();
    test_misc_ops();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_main.md
ALU_MAIN -- requirements
Module: alu_main

Interface
REQ-001 clk  input  1  single system clock; all state updates on its rising edge.
REQ-002 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 numLeft  input  8  left operand data (unsigned).
REQ-004 clkNumLeft  input  1  load strobe for numLeft; synchronous to clk, not a clock.
REQ-005 numRight  input  8  right operand data (unsigned).
REQ-006 clkNumRight  input  1  load strobe for numRight; synchronous to clk, not a clock.
REQ-007 opChoose  input  8  operation word: [3:0] opcode, [4] carry/borrow-in, [7:5] reserved.
REQ-008 clkOpChoose  input  1  load strobe for opChoose; synchronous to clk, not a clock.
REQ-009 result  output  8  registered ALU result.

Function
REQ-010 Three internal registers SHALL exist: regL (8b), regR (8b), regOp (8b).
REQ-011 Each strobe SHALL be rising-edge detected in the clk domain: a load occurs on the clk edge where the strobe samples 1 and its previously sampled value was 0.
REQ-012 A strobe held high SHALL cause exactly one load; re-load requires return to 0 for at least one clk cycle.
REQ-013 On a load, the matching register SHALL capture its data input as sampled on that same clk edge.
REQ-014 Simultaneous strobe edges SHALL load all affected registers on the same clk edge, independently.
REQ-015 result SHALL be a register updated every clk edge from the ALU function of the current regL, regR, regOp; latency from load edge to result: 1 clk.
REQ-016 Opcode map (L=regL, R=regR, c=regOp[4]), all results truncated to 8 bits:
 0x0 L; 0x1 L+R+c; 0x2 L-R-c; 0x3 L&R; 0x4 L|R; 0x5 L^R; 0x6 ~L;
 0x7 L<<R[2:0]; 0x8 L>>R[2:0] (logical); 0x9 rotate-left L by R[2:0]; 0xA rotate-right L by R[2:0];
 0xB L+1; 0xC L-1; 0xD low byte of L*R; 0xE 8'h01 if L<R else 8'h00; 0xF 8'h00.
REQ-017 Add/subtract SHALL wrap modulo 256 (0xFF+0x01 -> 0x00; 0x00-0x01 -> 0xFF); no carry/flag outputs.
REQ-018 regOp[7:5] SHALL be ignored; regOp[4] SHALL affect only opcodes 0x1 and 0x2.
REQ-019 Shift/rotate amount 0 SHALL return L unchanged.
REQ-020 Data inputs SHALL have no effect except on a load edge.

Reset
REQ-021 While rst=1 at a clk edge: regL, regR, regOp, result SHALL become 0x00 and all strobe-history bits SHALL become 0.
REQ-022 rst SHALL override any load on the same edge; a strobe already high when rst deasserts SHALL produce a load on the first non-reset edge where it is sampled high (history cleared to 0).
REQ-023 After reset with no loads, result SHALL remain 0x00 (opcode 0x0 passes regL=0).

Verification
REQ-024 Reset, then numLeft=3, numRight=11, opChoose=0x11, all three strobes pulsed high together for one cycle -> result=0x0F (3+11+1) one clk after the load edge, held afterward.
REQ-025 regL=0xFF, regR=0x01, opChoose=0x01 -> result=0x00; then opChoose=0x12 loaded alone with regL=0x00, regR=0x01 -> result=0xFE.
REQ-026 Strobe held high 5 cycles while numLeft changes 0x10->0x20 -> regL stays 0x10 (opcode 0x0 result=0x10); second pulse after low cycle loads 0x20.
REQ-027 regL=0x81, regR=0x01: opcode 0x9 -> 0x03; 0xA -> 0xC0; 0x7 -> 0x02; 0x8 -> 0x40; 0xD with regR=0x03 -> 0x83.
REQ-028 rst asserted mid-sequence with strobes high -> result=0x00 on that edge, registers cleared, no load until strobes sampled high after rst deasserts.
REQ-029 regL=0x05, regR=0x09: opcode 0xE -> 0x01; swap operands -> 0x00; opChoose=0xE3 (reserved bits set) -> 0x01 (AND of 0x05,0x09).
